// File: rtl/rgb2gray_if.sv
// RGB source / gray sink bus of the rgb2gray converter.
interface rgb2gray_if #(
    parameter int unsigned In_Width   = 8,
    parameter int unsigned Out_Width  = 8,
    parameter int unsigned Addr_Width = 16
);
    logic                    rgb_ready;
    logic                    rgb_req;
    logic [Addr_Width-1:0]   rgb_addr;
    logic [3*In_Width-1:0]   rgb_data;
    logic                    gray_valid;
    logic [Addr_Width-1:0]   gray_addr;
    logic [Out_Width-1:0]    gray_data;
    logic                    finish;

    // Converter side
    modport master (
        input  rgb_ready, rgb_data,
        output rgb_req, rgb_addr, gray_valid, gray_addr, gray_data, finish
    );

    // Memory side (RGB source plus gray sink)
    modport slave (
        output rgb_ready, rgb_data,
        input  rgb_req, rgb_addr, gray_valid, gray_addr, gray_data, finish
    );
endinterface

// File: rtl/rgb2gray.sv
// rgb2gray: streams one frame from an RGB memory, writes luma (77R+150G+29B)>>8
// into a gray memory through a 2-stage pipeline, then raises finish until reset.
// Define RGB2GRAY_ROUND_EN to add +128 before the shift (round-half-up);
// otherwise the result is truncated. Timing is identical in both builds.
module rgb2gray #(
    parameter int unsigned In_Width   = 8,
    parameter int unsigned Out_Width  = 8,
    parameter int unsigned Addr_Width = 16,
    parameter int unsigned N_PIX      = 65536
) (
    input  logic        clk,
    input  logic        rst,
    rgb2gray_if.master  bus
);
    localparam int unsigned Sum_Width = In_Width + 8;
    localparam logic [Addr_Width-1:0] Last_Addr = Addr_Width'(N_PIX - 1);
`ifdef RGB2GRAY_ROUND_EN
    localparam logic [Sum_Width-1:0] Round_Term = Sum_Width'(128);
`else
    localparam logic [Sum_Width-1:0] Round_Term = Sum_Width'(0);
`endif

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                state, state_d;
    logic                  drain_cnt;
    logic [Addr_Width-1:0] addr_q, addr_d;
    logic                  req_c;
    logic                  finish_q;

    logic                  s1_valid;
    logic [In_Width-1:0]   s1_r, s1_g, s1_b;
    logic [Addr_Width-1:0] s1_addr;
    logic                  s2_valid;
    logic [Sum_Width-1:0]  s2_sum;
    logic [Addr_Width-1:0] s2_addr;
    logic [Sum_Width-1:0]  sum_c;

    // Next state, fetch strobe and address advance; last address is held, never wrapped
    always_comb begin
        state_d = state;
        addr_d  = addr_q;
        req_c   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.rgb_ready) state_d = FETCH;
            end
            FETCH: begin
                req_c = bus.rgb_ready;
                if (req_c) begin
                    if (addr_q == Last_Addr) state_d = DRAIN;
                    else                     addr_d  = addr_q + Addr_Width'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt) state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, fetch address, drain timer and finish flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            drain_cnt <= 1'b0;
            finish_q  <= 1'b0;
        end else begin
            state     <= state_d;
            addr_q    <= addr_d;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            finish_q  <= (state_d == DONE);
        end
    end

    // Weighted sum of the stage-1 pixel
    always_comb begin
        sum_c = Sum_Width'(s1_r) * Sum_Width'(77)
              + Sum_Width'(s1_g) * Sum_Width'(150)
              + Sum_Width'(s1_b) * Sum_Width'(29)
              + Round_Term;
    end

    // Two-stage pipeline: stage 1 holds the raw pixel, stage 2 the sum
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
            s1_addr  <= '0;
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_addr  <= '0;
        end else begin
            s1_valid <= req_c;
            if (req_c) begin
                s1_r    <= bus.rgb_data[3*In_Width-1 -: In_Width];
                s1_g    <= bus.rgb_data[2*In_Width-1 -: In_Width];
                s1_b    <= bus.rgb_data[In_Width-1:0];
                s1_addr <= addr_q;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum  <= sum_c;
                s2_addr <= s1_addr;
            end
        end
    end

    assign bus.rgb_req    = req_c;
    assign bus.rgb_addr   = addr_q;
    assign bus.gray_valid = s2_valid;
    assign bus.gray_addr  = s2_addr;
    assign bus.gray_data  = s2_sum[Sum_Width-1 -: Out_Width];
    assign bus.finish     = finish_q;
endmodule

// File: tb/tb_rgb2gray.sv
// Bench for rgb2gray: behavioural RGB memory, scoreboard on the gray stream,
// table of known pixels, stall, mid-frame reset and a full all-white frame.
module tb_rgb2gray;
    localparam int N_PIX = 65536;
    localparam int N_VEC = 8;

    typedef struct {
        logic [7:0] r, g, b;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    bit   mode_ff = 1'b0;

    rgb2gray_if #(.In_Width(8), .Out_Width(8), .Addr_Width(16)) bus ();

    rgb2gray #(.In_Width(8), .Out_Width(8), .Addr_Width(16), .N_PIX(N_PIX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t       vec [N_VEC];
    logic [7:0] got [N_VEC];
    bit         seen[N_VEC];
    exp_t       q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         pulse_cnt = 0;
    int         last_pulse_cyc = 0;
    bit         finish_seen = 1'b0;
    logic [15:0] exp_req_addr = '0;

    task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [23:0] pix_at(input logic [15:0] a, input bit ff);
        if (ff) return 24'hFFFFFF;
        if (int'(a) < N_VEC) return {vec[a[2:0]].r, vec[a[2:0]].g, vec[a[2:0]].b};
        return {a[7:0], a[15:8] ^ 8'h3C, a[7:0] + a[15:8]};
    endfunction

    function automatic logic [7:0] gray_model(input logic [23:0] p);
        int unsigned s;
        s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
`ifdef RGB2GRAY_ROUND_EN
        s = s + 128;
`endif
        return 8'(s >> 8);
    endfunction

    // RGB memory answers in the same cycle as the request
    assign bus.rgb_data = pix_at(bus.rgb_addr, mode_ff);

    // Scoreboard: push on each request, pop on each gray write
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            q.delete();
            exp_req_addr = '0;
            pulse_cnt    = 0;
            finish_seen  = 1'b0;
        end else begin
            if (bus.rgb_req) begin
                chk("req_addr_seq", bus.rgb_addr == exp_req_addr, bus.rgb_addr, exp_req_addr);
                q.push_back('{addr: bus.rgb_addr, data: gray_model(pix_at(bus.rgb_addr, mode_ff)), cyc: cyc});
                exp_req_addr = exp_req_addr + 16'd1;
            end
            if (bus.gray_valid) begin
                if (q.size() == 0) begin
                    chk("gray_unexpected", 1'b0, bus.gray_addr, 0);
                end else begin
                    e = q.pop_front();
                    chk("gray_addr", bus.gray_addr == e.addr, bus.gray_addr, e.addr);
                    chk("gray_data", bus.gray_data == e.data, bus.gray_data, e.data);
                    chk("gray_latency", cyc == e.cyc + 2, cyc - e.cyc, 2);
                end
                if (!mode_ff && int'(bus.gray_addr) < N_VEC) begin
                    got[bus.gray_addr[2:0]]  = bus.gray_data;
                    seen[bus.gray_addr[2:0]] = 1'b1;
                end
                pulse_cnt++;
                last_pulse_cyc = cyc;
            end
            if (bus.finish && !finish_seen) begin
                finish_seen = 1'b1;
                chk("finish_count", pulse_cnt == N_PIX, pulse_cnt, N_PIX);
                chk("finish_timing", cyc == last_pulse_cyc + 1, cyc - last_pulse_cyc, 1);
            end
        end
    end

    task automatic wait_addr(input logic [15:0] a);
        int n = 0;
        while (bus.rgb_addr != a && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_addr", bus.rgb_addr == a, bus.rgb_addr, a);
    endtask

    initial begin
        #(10 * 98000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vec[0] = '{8'h00, 8'h00, 8'h00, 8'h00};
        vec[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
`ifdef RGB2GRAY_ROUND_EN
        vec[2] = '{8'h01, 8'h01, 8'h00, 8'h01};
        vec[3] = '{8'hFF, 8'h00, 8'h00, 8'h4D};
        vec[6] = '{8'h00, 8'h00, 8'hFF, 8'h1D};
`else
        vec[2] = '{8'h01, 8'h01, 8'h00, 8'h00};
        vec[3] = '{8'hFF, 8'h00, 8'h00, 8'h4C};
        vec[6] = '{8'h00, 8'h00, 8'hFF, 8'h1C};
`endif
        vec[4] = '{8'h00, 8'hFF, 8'h00, 8'h95};
        vec[5] = '{8'h10, 8'h20, 8'h30, 8'h1D};
        vec[7] = '{8'h80, 8'h80, 8'h80, 8'h80};
        for (int i = 0; i < N_VEC; i++) begin
            seen[i] = 1'b0;
            got[i]  = '0;
        end

        // Reset with rgb_ready high: outputs must all be quiet
        rst = 1'b0;
        bus.rgb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb_req",    bus.rgb_req == 1'b0,    bus.rgb_req, 0);
        chk("rst_rgb_addr",   bus.rgb_addr == 16'h0,  bus.rgb_addr, 0);
        chk("rst_gray_valid", bus.gray_valid == 1'b0, bus.gray_valid, 0);
        chk("rst_gray_addr",  bus.gray_addr == 16'h0, bus.gray_addr, 0);
        chk("rst_gray_data",  bus.gray_data == 8'h0,  bus.gray_data, 0);
        chk("rst_finish",     bus.finish == 1'b0,     bus.finish, 0);

        // Idle while the source is not ready
        bus.rgb_ready = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("idle_hold", !bus.rgb_req && bus.rgb_addr == 16'h0, bus.rgb_req, 0);
        end
        bus.rgb_ready = 1'b1;

        // Three-cycle stall at address 100
        wait_addr(16'd100);
        bus.rgb_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) bus.rgb_ready = 1'b1;
            @(negedge clk);
            if (k < 3)  chk("stall_hold", bus.rgb_addr == 16'd100 && !bus.rgb_req, bus.rgb_addr, 100);
            if (k == 3) chk("stall_resume", bus.rgb_addr == 16'd100 && bus.rgb_req, bus.rgb_addr, 100);
            if (k >= 2) chk("stall_bubble", !bus.gray_valid, bus.gray_valid, 0);
            @(posedge clk); #1;
        end

        // Mid-frame reset at 0x4000, then an all-white frame
        wait_addr(16'h4000);
        rst = 1'b0;
        mode_ff = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rgb_req",    bus.rgb_req == 1'b0,    bus.rgb_req, 0);
        chk("midrst_rgb_addr",   bus.rgb_addr == 16'h0,  bus.rgb_addr, 0);
        chk("midrst_gray_valid", bus.gray_valid == 1'b0, bus.gray_valid, 0);
        chk("midrst_gray_addr",  bus.gray_addr == 16'h0, bus.gray_addr, 0);
        chk("midrst_gray_data",  bus.gray_data == 8'h0,  bus.gray_data, 0);
        chk("midrst_finish",     bus.finish == 1'b0,     bus.finish, 0);
        rst = 1'b1;

        for (int i = 0; i < N_VEC; i++)
            chk($sformatf("vec%0d", i), seen[i] && got[i] == vec[i].exp, got[i], vec[i].exp);

        @(posedge clk); #1;
        chk("refetch_at_0", bus.rgb_req && bus.rgb_addr == 16'h0, bus.rgb_addr, 0);

        n = 0;
        while (!bus.finish && n < 70000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("finish_seen", bus.finish == 1'b1, bus.finish, 1);
        chk("pulse_count", pulse_cnt == N_PIX, pulse_cnt, N_PIX);
        chk("queue_empty", q.size() == 0, q.size(), 0);

        // DONE ignores rgb_ready and holds the last address
        for (int k = 0; k < 16; k++) begin
            bus.rgb_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("done_hold", bus.finish && !bus.rgb_req && !bus.gray_valid && bus.rgb_addr == 16'hFFFF,
                bus.rgb_addr, 16'hFFFF);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
